// File: rtl/d7s_pkg.sv
// Shared constants for the seven-segment scan decoder:
// active-low ABCDEFG patterns, digit slot indices and FSM states.
package d7s_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int UNITS    = 0;
    localparam int TENS     = 1;
    localparam int HUNDREDS = 2;

    typedef enum logic [1:0] {
        COLLECT,
        CONVERT,
        PUBLISH
    } state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one active-low segment pattern into a digit.
// A blank display reads as 0; anything else unknown is flagged illegal.
module seg7_to_bcd
    import d7s_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       legal
);

    always_comb begin
        digit = 4'd0;
        legal = 1'b1;
        case (seg)
            SEG_0, SEG_BLANK: digit = 4'd0;
            SEG_1:            digit = 4'd1;
            SEG_2:            digit = 4'd2;
            SEG_3:            digit = 4'd3;
            SEG_4:            digit = 4'd4;
            SEG_5:            digit = 4'd5;
            SEG_6:            digit = 4'd6;
            SEG_7:            digit = 4'd7;
            SEG_8:            digit = 4'd8;
            SEG_9:            digit = 4'd9;
            default:          legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Reconstructs the 0-255 value shown on a multiplexed 3-digit display
// by debouncing each scanned digit and assembling complete frames.
module seg_scan_decoder
    import d7s_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] transistor,
    input  logic [6:0] d7sp,
    output logic [7:0] value,
    output logic       value_valid,
    output logic       seg_err,
    output logic       range_err,
    output logic       stale
);

    localparam int DW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DW-1:0] DWELL_MAX = DW'(SETTLE_CYCLES);
    localparam logic [DW-1:0] DWELL_HIT = DW'(SETTLE_CYCLES - 2);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_SET    = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    sel_q;
    logic [6:0]    seg_q;
    logic [2:0]    sel_p;
    logic [6:0]    seg_p;
    logic [DW-1:0] dwell;
    logic [TW-1:0] tcount;
    state_t        state;
    logic [2:0]    have;
    logic [3:0]    dig [3];

    logic          one_hot;
    logic          same;
    logic          capture;
    logic          take;
    logic [3:0]    digit;
    logic          legal;
    logic [2:0]    wr_mask;
    logic [2:0]    have_next;
    logic [9:0]    sum;
    logic          fits;

    seg7_to_bcd u_dec (
        .seg   (seg_q),
        .digit (digit),
        .legal (legal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q <= '0;
            seg_q <= '0;
            sel_p <= '0;
            seg_p <= '0;
        end else begin
            sel_q <= transistor;
            seg_q <= d7sp;
            sel_p <= sel_q;
            seg_p <= seg_q;
        end
    end

    assign one_hot = (sel_q == 3'b001) || (sel_q == 3'b010) || (sel_q == 3'b100);
    assign same    = (sel_q == sel_p) && (seg_q == seg_p);

    // Saturating at SETTLE_CYCLES makes the capture fire once per dwell.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell <= '0;
        end else if (one_hot && same) begin
            if (dwell != DWELL_MAX) dwell <= dwell + DW'(1);
        end else begin
            dwell <= '0;
        end
    end

    assign capture   = one_hot && same && (dwell == DWELL_HIT);
    assign take      = capture && (state == COLLECT);
    assign seg_err   = take && !legal;
    assign wr_mask   = (take && legal) ? sel_q : 3'b000;
    assign have_next = have | wr_mask;

    assign sum = 10'(dig[HUNDREDS]) * 10'd100
               + 10'(dig[TENS]) * 10'd10
               + 10'(dig[UNITS]);
    assign fits = (sum <= 10'd255);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= COLLECT;
            have        <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            range_err   <= 1'b0;
            for (int i = 0; i < 3; i++) dig[i] <= '0;
        end else begin
            value_valid <= 1'b0;
            range_err   <= 1'b0;
            unique case (state)
                COLLECT: begin
                    have <= have_next;
                    for (int i = 0; i < 3; i++)
                        if (wr_mask[i]) dig[i] <= digit;
                    if (&have_next) state <= CONVERT;
                end
                CONVERT: begin
                    have        <= '0;
                    value_valid <= fits;
                    range_err   <= !fits;
                    if (fits) value <= sum[7:0];
                    state <= PUBLISH;
                end
                PUBLISH: state <= COLLECT;
                default: state <= COLLECT;
            endcase
        end
    end

    // A publish in the same cycle as the timeout takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcount <= '0;
            stale  <= 1'b0;
        end else if (value_valid) begin
            tcount <= '0;
            stale  <= 1'b0;
        end else begin
            if (tcount != TO_MAX) tcount <= tcount + TW'(1);
            if (tcount >= TO_SET) stale <= 1'b1;
        end
    end

endmodule
